// File: rtl/op_share_arbiter_pkg.sv
// Shared definitions for the operator-sharing arbiter: opcodes, FSM encoding
// and the default datapath width.
package op_share_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_SHL = 2'b11
  } opcode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/op_share_arbiter_op_unit.sv
// Combinational shared operator: add, low-half multiply, signed truncating
// divide and left shift, all wrapping modulo 2^WIDTH.
module op_unit
  import op_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;

  assign sa = a;
  assign sb = b;

  // Divide by zero yields 0; the single overflowing quotient (min / -1) wraps to min.
  function automatic logic signed [WIDTH-1:0] sat_div(input logic signed [WIDTH-1:0] n,
                                                      input logic signed [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] min_v;
    min_v = {1'b1, {(WIDTH-1){1'b0}}};
    if (d == '0)
      return '0;
    else if (n == min_v && d == '1)
      return min_v;
    else
      return n / d;
  endfunction

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = sa + sb;
      OP_MUL:  result = sa * sb;
      OP_DIV:  result = sat_div(sa, sb);
      OP_SHL:  result = sa << sb[4:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/op_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle operator among N_REQ requesters,
// one operation in flight: IDLE (grant) -> EXEC (LATENCY cycles) -> RESP.
module op_share_arbiter
  import op_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [1:0]              state;
  logic [IDX_W-1:0]        last_grant;
  logic [CNT_W-1:0]        cnt;

  logic [1:0]              op_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [IDX_W-1:0]        win_p0;

  logic [N_REQ-1:0]        rsp_valid_p1;
  logic [WIDTH-1:0]        rsp_data_p1;

  logic [N_REQ-1:0]        grant;
  logic [IDX_W-1:0]        pick;
  logic                    found;
  logic                    accept;
  int                      idx;
  logic [IDX_W-1:0]        idx_w;
  logic [1:0]              sel_op;
  logic [WIDTH-1:0]        sel_a;
  logic [WIDTH-1:0]        sel_b;
  logic [WIDTH-1:0]        result;

  // Rotating priority: the search begins just after the most recent winner.
  always_comb begin
    grant  = '0;
    pick   = last_grant;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IDX_W'(idx);
      if (!found && req_valid[idx_w]) begin
        grant[idx_w] = 1'b1;
        pick         = idx_w;
        found        = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign accept    = (state == ST_IDLE) && !rst && found;
  assign req_ready = accept ? grant : '0;

  op_unit #(.WIDTH(WIDTH)) u_op_unit (
    .op     (op_p0),
    .a      (a_p0),
    .b      (b_p0),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= IDX_W'(N_REQ - 1);
      cnt          <= '0;
      op_p0        <= '0;
      a_p0         <= '0;
      b_p0         <= '0;
      win_p0       <= '0;
      rsp_valid_p1 <= '0;
      rsp_data_p1  <= '0;
    end else begin
      rsp_valid_p1 <= '0;
      rsp_data_p1  <= '0;
      case (state)
        // p0: operands captured at accept; nothing downstream reads the request bus again
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_EXEC;
            cnt        <= CNT_W'(LATENCY);
            last_grant <= pick;
            win_p0     <= pick;
            op_p0      <= sel_op;
            a_p0       <= sel_a;
            b_p0       <= sel_b;
          end
        end
        // p1: result registered on the final execute cycle, presented during RESP
        ST_EXEC: begin
          if (cnt == CNT_W'(1)) begin
            state                <= ST_RESP;
            cnt                  <= '0;
            rsp_valid_p1[win_p0] <= 1'b1;
            rsp_data_p1          <= result;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A reset landing in the RESP cycle suppresses the strobe immediately.
  assign rsp_valid = rst ? '0 : rsp_valid_p1;
  assign rsp_data  = rst ? '0 : rsp_data_p1;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_op_share_arbiter.sv
// Self-checking bench for op_share_arbiter: directed scenarios plus random
// traffic scored against an arithmetic reference model.
module tb_op_share_arbiter;
  import op_share_arbiter_pkg::*;

  localparam int N = 3;
  localparam int W = 32;
  localparam int L = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int tb_lg  = N - 1;

  typedef struct {
    int           due;
    int           idx;
    logic [W-1:0] data;
  } exp_t;
  exp_t sbq[$];

  op_share_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic in 64 bits, keeping the low W bits.
  function automatic logic [W-1:0] model_op(input logic [1:0] op, input logic [W-1:0] ua,
                                            input logic [W-1:0] ub);
    longint a, b, r;
    a = longint'(signed'(ua));
    b = longint'(signed'(ub));
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a * b;
      2'b10:   r = (b == 0) ? 64'sd0 : a / b;
      default: r = a << ub[4:0];
    endcase
    return r[W-1:0];
  endfunction

  function automatic int rr_pick(input int lg, input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (lg + k) % N;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  // Continuous handshake rules and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    assert ($onehot0(req_ready)) else begin
      errors++; $error("FAIL ready_onehot got=%b exp=at_most_one_bit", req_ready);
    end
    checks++;
    assert (!(busy || rst) || req_ready === '0) else begin
      errors++; $error("FAIL ready_outside_idle got=%b exp=000 busy=%b rst=%b", req_ready, busy, rst);
    end
    if (rst) begin
      sbq.delete();
    end else begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i])
          sbq.push_back('{cyc + L + 1, i,
                          model_op(req_op[2*i +: 2], req_a[W*i +: W], req_b[W*i +: W])});
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          assert (rsp_valid === '0) else begin
            errors++; $error("FAIL rsp_unexpected got=%b exp=000", rsp_valid);
          end
        end else begin
          e = sbq.pop_front();
          checks++;
          assert (rsp_valid === N'(1 << e.idx)) else begin
            errors++; $error("FAIL sb_rsp_valid got=%b exp=%b", rsp_valid, N'(1 << e.idx));
          end
          checks++;
          assert (rsp_data === e.data) else begin
            errors++; $error("FAIL sb_rsp_data got=%0h exp=%0h", rsp_data, e.data);
          end
          checks++;
          assert (cyc === e.due) else begin
            errors++; $error("FAIL sb_rsp_cycle got=%0d exp=%0d", cyc, e.due);
          end
        end
      end else begin
        checks++;
        assert (rsp_data === '0) else begin
          errors++; $error("FAIL rsp_data_idle got=%0h exp=0", rsp_data);
        end
        if (sbq.size() > 0 && cyc > sbq[0].due) begin
          checks++;
          assert (cyc <= sbq[0].due) else begin
            errors++; $error("FAIL sb_rsp_missing got=none exp=rsp_at_cycle_%0d", sbq[0].due);
          end
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  task automatic wait_any_accept(output int idx, output int t);
    bit ok;
    ok  = 1'b0;
    idx = -1;
    t   = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != '0) begin
        ok = 1'b1;
        t  = cyc;
        for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
        break;
      end
    end
    checks++;
    assert (ok) else begin
      errors++; $error("FAIL accept_timeout got=no_grant exp=grant");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
    tb_lg = N - 1;
  endtask

  task automatic do_single(input int i, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp, input string tag);
    int idx, t;
    req_valid = '0;
    set_req(i, op, a, b);
    req_valid[i] = 1'b1;
    wait_any_accept(idx, t);
    check({tag, "_winner"}, W'(idx), W'(i));
    step();
    req_valid[i] = 1'b0;
    set_req(i, 2'($urandom), $urandom, $urandom);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      check({tag, "_early"}, W'(rsp_valid), '0);
    end
    @(negedge clk);
    check({tag, "_valid"}, W'(rsp_valid), W'(1 << i));
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_latency"}, W'(cyc - t), W'(L + 1));
    tb_lg = i;
    step();
  endtask

  initial begin
    int idx, t, prev, exp_idx;
    int rr_exp[4];
    logic [N-1:0] pend;
    logic [1:0] op;
    logic [W-1:0] a, b;

    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 2'($urandom), $urandom, $urandom);
    @(negedge clk);
    check("rst_ready", W'(req_ready), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_rsp_valid", W'(rsp_valid), '0);
    check("rst_rsp_data", rsp_data, '0);
    req_valid = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", W'(busy), '0);
    check("post_rst_ready", W'(req_ready), '0);
    step();

    do_single(0, OP_DIV, -32'sd7, 32'sd2, -32'sd3, "div_neg");
    do_single(1, OP_DIV, 32'sd5, 32'sd0, 32'sd0, "div_zero");
    do_single(2, OP_DIV, 32'sh80000000, -32'sd1, 32'sh80000000, "div_ovf");
    do_single(0, OP_SHL, 32'sd1, 32'sd33, 32'sd2, "shl_wrap");
    do_single(1, OP_MUL, 32'sd65536, 32'sd65536, 32'sd0, "mul_wrap");
    do_single(2, OP_ADD, 32'h7fffffff, 32'sd1, 32'h80000000, "add_wrap");

    // Round-robin from reset with all requesters continuously valid.
    do_reset();
    rr_exp = '{0, 1, 2, 0};
    for (int i = 0; i < N; i++) set_req(i, 2'($urandom), $urandom, $urandom);
    req_valid = '1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any_accept(idx, t);
      check("rr_order", W'(idx), W'(rr_exp[k]));
      if (k > 0) check("rr_spacing", W'(t - prev), W'(L + 2));
      prev = t;
      step();
      if (idx >= 0) set_req(idx, 2'($urandom), $urandom, $urandom);
    end
    req_valid = '0;
    tb_lg = 0;
    repeat (L + 2) step();

    // Reset during the first execute cycle abandons the operation.
    set_req(1, OP_ADD, 32'd10, 32'd20);
    req_valid[1] = 1'b1;
    wait_any_accept(idx, t);
    check("midrst_winner", W'(idx), W'(2'd1));
    step();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", W'(req_ready), '0);
    check("midrst_rsp", W'(rsp_valid), '0);
    step();
    rst = 1'b0;
    for (int k = 0; k < L + 3; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", W'(rsp_valid), '0);
    end
    check("midrst_idle", W'(busy), '0);
    step();
    for (int i = 0; i < N; i++) set_req(i, 2'($urandom), $urandom, $urandom);
    req_valid = '1;
    wait_any_accept(idx, t);
    check("midrst_first_winner", W'(idx), '0);
    step();
    req_valid = '0;
    tb_lg = 0;
    repeat (L + 2) step();

    // A valid withdrawn before the arbiter returns to IDLE is never granted.
    set_req(0, OP_ADD, 32'd1, 32'd2);
    req_valid[0] = 1'b1;
    wait_any_accept(idx, t);
    step();
    req_valid[0] = 1'b0;
    set_req(1, OP_MUL, 32'd3, 32'd4);
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    set_req(2, OP_SHL, 32'd5, 32'd3);
    req_valid[2] = 1'b1;
    wait_any_accept(idx, t);
    check("drop_not_granted", W'(idx), W'(2'd2));
    step();
    req_valid = '0;
    tb_lg = 2;
    repeat (L + 2) step();

    // Random contention rounds: each pending request held until its grant.
    for (int r = 0; r < 12; r++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_req(i, 2'($urandom), $urandom, $urandom_range(0, 40));
      req_valid = pend;
      while (pend != '0) begin
        exp_idx = rr_pick(tb_lg, pend);
        wait_any_accept(idx, t);
        check("rand_rr_winner", W'(idx), W'(exp_idx));
        if (idx < 0) break;
        tb_lg = idx;
        step();
        pend[idx] = 1'b0;
        req_valid[idx] = 1'b0;
      end
      req_valid = '0;
      repeat (L + 2) step();
    end

    // Random single operations, including corner operands.
    for (int r = 0; r < 24; r++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = '1;
        2:       b = $urandom_range(0, 63);
        default: b = $urandom;
      endcase
      idx = $urandom_range(0, N - 1);
      do_single(idx, op, a, b, model_op(op, a, b), "rand_op");
    end

    repeat (L + 3) step();
    check("sb_drained", W'(sbq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_share_arbiter.md
OP_SHARE_ARBITER -- requirements
Module: op_share_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_REQ, 3, number of requesters.
- WIDTH, 32, operand/result width.
- LATENCY, 2, execute cycles of the shared operator, >=1.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- req_valid, in, N_REQ, per-requester request valid.
- req_ready, out, N_REQ, per-requester accept; at most one bit set.
- req_op, in, 2*N_REQ, opcode per requester; requester i uses bits [2i+1:2i].
- req_a, in, WIDTH*N_REQ, signed operand A per requester.
- req_b, in, WIDTH*N_REQ, signed operand B per requester.
- rsp_valid, out, N_REQ, one-hot result strobe, asserted for one cycle.
- rsp_data, out, WIDTH, result; meaningful only while rsp_valid != 0.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 The block SHALL share one operator unit among N_REQ requesters, with one operation in flight at a time.
REQ-004 Opcodes SHALL be:
- 00: A+B.
- 01: A*B, low WIDTH bits.
- 10: A/B, signed, truncating toward zero.
- 11: A << B[4:0].
- All results wrap modulo 2^WIDTH.
REQ-005 Divide by zero SHALL return 0; (-2^31)/(-1) SHALL return -2^31.
REQ-006 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-007 In IDLE with any req_valid set, the block SHALL choose a winner by round-robin:
- Search starts at index (last_grant+1) mod N_REQ.
- It SHALL assert req_ready for the winner only, combinationally in that cycle.
- It SHALL latch the winner's op, A, B and index.
- It SHALL go to EXEC.
REQ-008 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high. req_ready SHALL be 0 outside IDLE.
REQ-009 Requesters SHALL hold valid, op and operands stable until accepted. The block SHALL NOT depend on operand values after the accept cycle.
REQ-010 EXEC SHALL last exactly LATENCY cycles, counted by a down-counter loaded at accept. The block SHALL then enter RESP.
REQ-011 RESP SHALL last one cycle:
- rsp_valid[winner] = 1.
- rsp_data = result.
- Next state is IDLE.
REQ-012 Timing:
- Accept-to-response latency SHALL be LATENCY+1 cycles (accept in cycle t, rsp_valid in cycle t+LATENCY+1).
- Back-to-back throughput SHALL be one operation per LATENCY+2 cycles.
REQ-013 last_grant SHALL update only on an accepted transfer. Simultaneous requests SHALL be served in rotating order, so no requester starves.
REQ-014 A requester deasserting valid before accept SHALL NOT be granted. Deasserting valid in other states SHALL have no effect.
REQ-015 rsp_data SHALL be 0 whenever rsp_valid is all-zero.

Reset
REQ-016 On rst, at the next edge:
- state = IDLE.
- last_grant = N_REQ-1, so requester 0 has first priority.
- counter, latched operands and rsp_data = 0.
- req_ready = 0, rsp_valid = 0, busy = 0.
REQ-017 rst asserted during EXEC or RESP SHALL abandon the operation with no rsp_valid pulse. rst SHALL take priority over every other event in the same cycle.
REQ-018 req_ready SHALL be 0 during any cycle in which rst is high.

Structure
REQ-019 A shared package SHALL hold:
- the opcode enumeration (OP_ADD, OP_MUL, OP_DIV, OP_SHL);
- the FSM state encoding;
- default WIDTH.
REQ-020 The operator SHALL be one sub-module, op_unit: purely combinational, inputs op/A/B, output result, implementing REQ-004 and REQ-005. The arbiter SHALL instantiate it once.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single request: req 0, op=10, A=-7, B=2 → rsp_valid=001 with rsp_data=-3, 3 cycles after accept (LATENCY=2).
- Divide by zero: op=10, A=5, B=0 → rsp_data=0. Overflow: A=-2147483648, B=-1 → rsp_data=-2147483648.
- Round-robin after reset: all three requesters valid continuously → accepts in order 0,1,2,0; every accept is 4 cycles apart.
- Shift and multiply: op=11, A=1, B=33 → rsp_data=2. op=01, A=65536, B=65536 → rsp_data=0.
- Reset mid-operation: rst asserted in the 1st EXEC cycle → no rsp_valid; after reset, requester 0 wins again.
- Handshake contract: req_ready never high in EXEC or RESP; req_ready never has more than one bit set; a valid dropped before accept is never granted.
